// File: rtl/alu_bist.sv
// alu_bist: self-test driver and checker for the 4-bit combinational alu (a, b, s -> y).
// Optional first-failure capture into fail_info is built when ALU_BIST_FAIL_CAPTURE_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start, outputs at reset values
// DRIVE  | current vector held on alu_a/b/s while the settle counter runs down
// SAMPLE | compare alu_y against the golden value, step to the next vector
// DONE   | run finished, result held until start or reset
module alu_bist #(
    parameter int unsigned NUM_VECTORS   = 8,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [7:0]  SEED          = 8'hA5
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               start,
    output logic [3:0]                         alu_a,
    output logic [3:0]                         alu_b,
    output logic [1:0]                         alu_s,
    input  logic [3:0]                         alu_y,
    output logic                               busy,
    output logic                               done,
    output logic                               pass,
    output logic [$clog2(NUM_VECTORS+1)-1:0]   err_count,
    output logic [13:0]                        fail_info
);

    localparam int EC_W  = $clog2(NUM_VECTORS + 1);
    localparam int IDX_W = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    // An all-zero seed would lock the LFSR, so it is promoted to 1.
    localparam logic [7:0]       SEED_EFF    = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_VECTORS - 1);
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             load_run;
    logic             step;
    logic [7:0]       lfsr;
    logic             lfsr_fb;
    logic [IDX_W-1:0] idx;
    logic [1:0]       vec_s;
    logic [SET_W-1:0] settle_cnt;
    logic [3:0]       golden;
    logic             mismatch;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_run  = 1'b0;
        step      = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = DRIVE;
                    load_run  = 1'b1;
                end
            end
            DRIVE: begin
                if (settle_cnt == '0) begin
                    state_nxt = SAMPLE;
                end
            end
            SAMPLE: begin
                if (idx == LAST_IDX) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = DRIVE;
                    step      = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        golden = 4'h0;
        case (alu_s)
            2'b00:   golden = alu_a & alu_b;
            2'b01:   golden = alu_a | alu_b;
            2'b10:   golden = alu_a + alu_b;
            default: golden = alu_a - alu_b;
        endcase
    end

    // Case equality so an X/Z result at the sample edge is scored as a miss.
    assign mismatch = (state == SAMPLE) && !(alu_y === golden);

    // x^8+x^6+x^5+x^4+1, shifting left: taps at bits 7,5,4,3.
    assign lfsr_fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lfsr       <= 8'h00;
            idx        <= '0;
            vec_s      <= 2'd0;
            settle_cnt <= '0;
            err_count  <= '0;
        end else if (load_run) begin
            lfsr       <= SEED_EFF;
            idx        <= '0;
            vec_s      <= 2'd0;
            settle_cnt <= SETTLE_LOAD;
            err_count  <= '0;
        end else begin
            if (state == DRIVE && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - SET_W'(1);
            end
            if (mismatch) begin
                err_count <= err_count + EC_W'(1);
            end
            if (step) begin
                lfsr       <= {lfsr[6:0], lfsr_fb};
                idx        <= idx + IDX_W'(1);
                vec_s      <= vec_s + 2'd1;
                settle_cnt <= SETTLE_LOAD;
            end
        end
    end

    assign alu_a = lfsr[7:4];
    assign alu_b = lfsr[3:0];
    assign alu_s = vec_s;
    assign busy  = (state == DRIVE) || (state == SAMPLE);
    assign done  = (state == DONE);
    assign pass  = (state == DONE) && (err_count == '0);

`ifdef ALU_BIST_FAIL_CAPTURE_EN
    logic [13:0] fail_q;

    // Only the first miss of a run is kept; err_count==0 marks it as the first.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fail_q <= 14'h0;
        end else if (load_run) begin
            fail_q <= 14'h0;
        end else if (mismatch && err_count == '0) begin
            fail_q <= {alu_a, alu_b, alu_s, alu_y};
        end
    end

    assign fail_info = fail_q;
`else
    assign fail_info = 14'h0;
`endif

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: three instances (default, seed-0/single-vector, 3-cycle settle)
// each paired with a behavioural alu that can be corrupted on purpose.
module tb_alu_bist;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic [2:0]        start_w;
    logic [2:0][3:0]   a_w;
    logic [2:0][3:0]   b_w;
    logic [2:0][1:0]   s_w;
    logic [2:0][3:0]   y_w;
    logic [2:0]        busy_w;
    logic [2:0]        done_w;
    logic [2:0]        pass_w;
    logic [2:0][3:0]   ec_w;
    logic [2:0][13:0]  fi_w;
    logic [0:0]        ec1;

    int          fmode [3];
    logic [15:0] fault_tab;
    logic [3:0]  fault_xor;

    int n_vec;
    int n_bad;

    function automatic logic [3:0] gold(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s);
        case (s)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return 4'((int'(a) + int'(b)) % 16);
            default: return 4'((int'(a) - int'(b) + 16) % 16);
        endcase
    endfunction

    // mode 0: correct alu, 1: y[0] inverted, 2: table-selected corruption keyed by a
    function automatic logic [3:0] alu_out(input logic [3:0] a, input logic [3:0] b, input logic [1:0] s,
                                           input int mode, input logic [15:0] tab, input logic [3:0] xm);
        logic [3:0] g;
        g = gold(a, b, s);
        if (mode == 1) return g ^ 4'h1;
        if (mode == 2 && tab[a]) return g ^ xm;
        return g;
    endfunction

    assign y_w[0] = alu_out(a_w[0], b_w[0], s_w[0], fmode[0], fault_tab, fault_xor);
    assign y_w[1] = alu_out(a_w[1], b_w[1], s_w[1], fmode[1], fault_tab, fault_xor);
    assign y_w[2] = alu_out(a_w[2], b_w[2], s_w[2], fmode[2], fault_tab, fault_xor);
    assign ec_w[1] = {3'b000, ec1};

    alu_bist u_dut0 (
        .clk(clk), .reset_n(reset_n), .start(start_w[0]),
        .alu_a(a_w[0]), .alu_b(b_w[0]), .alu_s(s_w[0]), .alu_y(y_w[0]),
        .busy(busy_w[0]), .done(done_w[0]), .pass(pass_w[0]),
        .err_count(ec_w[0]), .fail_info(fi_w[0])
    );

    alu_bist #(.NUM_VECTORS(1), .SETTLE_CYCLES(1), .SEED(8'h00)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .start(start_w[1]),
        .alu_a(a_w[1]), .alu_b(b_w[1]), .alu_s(s_w[1]), .alu_y(y_w[1]),
        .busy(busy_w[1]), .done(done_w[1]), .pass(pass_w[1]),
        .err_count(ec1), .fail_info(fi_w[1])
    );

    alu_bist #(.NUM_VECTORS(8), .SETTLE_CYCLES(3), .SEED(8'hA5)) u_dut2 (
        .clk(clk), .reset_n(reset_n), .start(start_w[2]),
        .alu_a(a_w[2]), .alu_b(b_w[2]), .alu_s(s_w[2]), .alu_y(y_w[2]),
        .busy(busy_w[2]), .done(done_w[2]), .pass(pass_w[2]),
        .err_count(ec_w[2]), .fail_info(fi_w[2])
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete run on instance u, checked cycle by cycle against the reference model.
    // pulse_at: run clock (1-based after accept) at which an extra start pulse is sampled; hold: start kept high.
    task automatic do_run(input int u, input int n, input int st, input logic [7:0] seed,
                          input string tag, input int pulse_at, input bit hold);
        logic [3:0]  ea [8];
        logic [3:0]  eb [8];
        logic [1:0]  es [8];
        logic [3:0]  y;
        logic [13:0] efi;
        int l, errs, cyc, total, k;
        l    = (seed == 8'h00) ? 1 : int'(seed);
        errs = 0;
        efi  = 14'h0;
        for (int i = 0; i < n; i++) begin
            ea[i] = 4'(l / 16);
            eb[i] = 4'(l % 16);
            es[i] = 2'(i % 4);
            y = alu_out(ea[i], eb[i], es[i], fmode[u], fault_tab, fault_xor);
            if (y !== gold(ea[i], eb[i], es[i])) begin
                if (errs == 0) efi = {ea[i], eb[i], es[i], y};
                errs++;
            end
            l = ((l * 2) + ($countones(l & 'hB8) % 2)) % 256;
        end
`ifndef ALU_BIST_FAIL_CAPTURE_EN
        efi = 14'h0;
`endif
        total = n * (st + 1);

        start_w[u] = 1'b1;
        tick();
        cyc = 0;
        while (done_w[u] !== 1'b1 && cyc < total + 4) begin
            k = cyc / (st + 1);
            if (k > n - 1) k = n - 1;
            n_vec++;
            if ({busy_w[u], a_w[u], b_w[u], s_w[u]} !== {1'b1, ea[k], eb[k], es[k]}) begin
                n_bad++;
                $display("FAIL %s vector clk %0d: got busy=%b a=%h b=%h s=%0d, want busy=1 a=%h b=%h s=%0d",
                         tag, cyc, busy_w[u], a_w[u], b_w[u], s_w[u], ea[k], eb[k], es[k]);
            end
            start_w[u] = hold || (cyc + 1 == pulse_at);
            tick();
            cyc++;
        end
        start_w[u] = 1'b0;

        n_vec++;
        if (cyc !== total) begin
            n_bad++;
            $display("FAIL %s latency: done after %0d clocks, want %0d", tag, cyc, total);
        end
        n_vec++;
        if ({busy_w[u], done_w[u], pass_w[u], ec_w[u]} !== {1'b0, 1'b1, (errs == 0), 4'(errs)}) begin
            n_bad++;
            $display("FAIL %s result: got busy=%b done=%b pass=%b err=%0d, want busy=0 done=1 pass=%b err=%0d",
                     tag, busy_w[u], done_w[u], pass_w[u], ec_w[u], (errs == 0), errs);
        end
        n_vec++;
        if (fi_w[u] !== efi) begin
            n_bad++;
            $display("FAIL %s fail_info: got %h, want %h", tag, fi_w[u], efi);
        end
        tick();
        n_vec++;
        if ({done_w[u], ec_w[u], fi_w[u]} !== {1'b1, 4'(errs), efi}) begin
            n_bad++;
            $display("FAIL %s hold: got done=%b err=%0d fi=%h, want done=1 err=%0d fi=%h",
                     tag, done_w[u], ec_w[u], fi_w[u], errs, efi);
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start_w = 3'b000;
        tick();
        tick();
        for (int u = 0; u < 3; u++) begin
            n_vec++;
            if ({a_w[u], b_w[u], s_w[u], busy_w[u], done_w[u], pass_w[u], ec_w[u], fi_w[u]} !== 31'h0) begin
                n_bad++;
                $display("FAIL reset inst%0d: got a=%h b=%h s=%0d busy=%b done=%b pass=%b err=%0d fi=%h, want all 0",
                         u, a_w[u], b_w[u], s_w[u], busy_w[u], done_w[u], pass_w[u], ec_w[u], fi_w[u]);
            end
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_correct();
        fmode[0] = 0;
        do_run(0, 8, 1, 8'hA5, "correct", -1, 1'b0);
    endtask

    task automatic test_inverted_y0();
        fmode[0] = 1;
        do_run(0, 8, 1, 8'hA5, "inv_y0", -1, 1'b0);
        fmode[0] = 0;
    endtask

    task automatic test_start_while_busy();
        do_run(0, 8, 1, 8'hA5, "pulse_busy", 5, 1'b0);
        do_run(0, 8, 1, 8'hA5, "hold_busy", -1, 1'b1);
    endtask

    task automatic test_reset_mid_run();
        start_w[0] = 1'b1;
        tick();
        start_w[0] = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        reset_n = 1'b0;
        #1;
        n_vec++;
        if ({a_w[0], b_w[0], s_w[0], busy_w[0], done_w[0], pass_w[0], ec_w[0], fi_w[0]} !== 31'h0) begin
            n_bad++;
            $display("FAIL mid_reset: got a=%h b=%h s=%0d busy=%b done=%b pass=%b err=%0d fi=%h, want all 0",
                     a_w[0], b_w[0], s_w[0], busy_w[0], done_w[0], pass_w[0], ec_w[0], fi_w[0]);
        end
        tick();
        reset_n = 1'b1;
        tick();
        do_run(0, 8, 1, 8'hA5, "after_reset", -1, 1'b0);
    endtask

    task automatic test_seed_zero();
        fmode[1] = 0;
        do_run(1, 1, 1, 8'h00, "seed0", -1, 1'b0);
        fmode[1] = 1;
        do_run(1, 1, 1, 8'h00, "seed0_bad", -1, 1'b0);
        fmode[1] = 0;
    endtask

    task automatic test_settle3();
        fmode[2] = 0;
        do_run(2, 8, 3, 8'hA5, "settle3", -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_run(0, 8, 1, 8'hA5, "b2b_first", -1, 1'b0);
        do_run(0, 8, 1, 8'hA5, "b2b_second", -1, 1'b0);
    endtask

    task automatic test_random_faults();
        for (int r = 0; r < 6; r++) begin
            fault_tab = 16'($urandom);
            fault_xor = 4'($urandom_range(1, 15));
            fmode[0]  = 2;
            fmode[2]  = 2;
            do_run(0, 8, 1, 8'hA5, "rand_u0", int'($urandom_range(1, 15)), 1'b0);
            do_run(2, 8, 3, 8'hA5, "rand_u2", int'($urandom_range(1, 31)), 1'b0);
        end
        fmode[0] = 0;
        fmode[2] = 0;
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        fmode[0]  = 0;
        fmode[1]  = 0;
        fmode[2]  = 0;
        fault_tab = 16'h0;
        fault_xor = 4'h1;
        test_reset();
        test_correct();
        test_inverted_y0();
        test_start_while_busy();
        test_reset_mid_run();
        test_seed_zero();
        test_settle3();
        test_back_to_back();
        test_random_faults();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
